payload_size_checker: RTL
=========================

// Module: payload_size_checker
// PURPOSE
//  Sits downstream of the header stage and beside the packet-detector control FSM.
//  Counts payload bytes while enable_payload is high and checks the count against
//  the type/length field latched from the header. Raises packet_size_valid, which
//  moves the control FSM out of its payload state, or packet_size_error on a bad size.
// PARAMETERS
//  MIN_PAYLOAD   46    minimum payload bytes; shorter frames are padded up to this
//  MAX_PAYLOAD   1500  maximum payload bytes; count beyond this is an error
//  TYPE_THRESH   1536  tl_value >= this is an EtherType, not a length (0x0600)
// PORTS
//  clock              in   1   rising-edge clock
//  reset              in   1   asynchronous, active-high reset
//  tl_load            in   1   1-cycle pulse: latch tl_value, arm the checker
//  tl_value           in   16  type/length field from the header stage
//  enable_payload     in   1   payload byte present on data this cycle
//  data               in   8   payload byte
//  packet_size_valid  out  1   1-cycle pulse: required payload size reached
//  packet_size_error  out  1   level: size violation, held until next tl_load/reset
//  byte_count         out  16  payload bytes accepted since last tl_load
//  crc_out            out  32  only with PAYLOAD_CRC_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, byte_count=0, packet_size_valid=0,
//   packet_size_error=0, expected=0, crc_out=32'hFFFFFFFF.
//  expected on tl_load: tl_value>=TYPE_THRESH -> MIN_PAYLOAD;
//   else max(tl_value, MIN_PAYLOAD). Lengths 1..45 count the padding bytes.
//  States:
//   IDLE : outputs idle. tl_load -> ARMED (latch expected, byte_count=0, error=0).
//   ARMED: enable_payload=1 -> byte_count+1. Moves to DONE when the new count == expected.
//          enable_payload 1->0 with count < expected -> ERROR (runt).
//          tl_load -> re-arm; the partial count is discarded.
//   DONE : packet_size_valid=1 for exactly the first cycle in DONE, which is
//          1 cycle after the byte that reached expected. Further enable_payload
//          bytes keep counting. Count > MAX_PAYLOAD -> ERROR (giant).
//          tl_load -> ARMED.
//   ERROR: packet_size_error=1. Counting stops. Only tl_load (-> ARMED) or reset leaves.
//  byte_count saturates at 16'hFFFF and does not wrap.
//  enable_payload outside ARMED/DONE is ignored.
//  tl_load has priority over a byte in the same cycle: the byte is dropped and the
//   new frame starts at count 0.
//  Reset asserted mid-frame: all state clears immediately. No pulse is emitted.
//  packet_size_valid and packet_size_error are never high together.
// CONFIGURATION
//  PAYLOAD_CRC_EN defined:
//   - crc_out exists: IEEE 802.3 CRC-32 (reflected, poly 0x04C11DB7).
//   - Accumulated over every accepted byte. Preset to 32'hFFFFFFFF on tl_load.
//   - Updated the same cycle as byte_count. Not complemented.
//   - Frozen in ERROR.
//  PAYLOAD_CRC_EN undefined: crc_out port and CRC logic are absent. All else identical.
// TESTING
//  1 tl_load tl=0x0040, 64 bytes -> valid pulse 1 cycle after byte 64, count=64, no error.
//  2 tl_load tl=0x0800, 46 bytes -> valid after byte 46; bytes 47..1500 -> no error;
//    byte 1501 -> error=1.
//  3 tl_load tl=0x0010, 46 bytes -> valid after byte 46 (padding counted); after byte 16 -> no pulse.
//  4 tl_load tl=0x0064, enable drops after 50 bytes -> error=1, valid never; tl_load clears error.
//  5 reset pulsed mid-frame at count 30 -> outputs at reset values same cycle;
//    tl_load together with a byte -> count=0.
//  6 [PAYLOAD_CRC_EN] bytes "123456789" -> ~crc_out == 32'hCBF43926;
//    macro off -> build has no crc_out.

Source files
------------

// File: rtl/payload_size_checker.sv
// Payload byte counter and size checker against the latched type/length field.
// Optional CRC-32 over accepted payload bytes when PAYLOAD_CRC_EN is defined.
module payload_size_checker #(
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500,
  parameter int TYPE_THRESH = 1536
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tl_load,
  input  logic [15:0] tl_value,
  input  logic        enable_payload,
  input  logic [7:0]  data,
  output logic        packet_size_valid,
  output logic        packet_size_error,
`ifdef PAYLOAD_CRC_EN
  output logic [15:0] byte_count,
  output logic [31:0] crc_out
`else
  output logic [15:0] byte_count
`endif
);

  typedef enum logic [1:0] {IDLE, ARMED, DONE, ERROR} state_t;

  state_t      state, state_n;
  logic [15:0] expected, expected_n;
  logic [15:0] count_n;
  logic [15:0] count_inc;
  logic        valid_n;

  // EtherType frames and short lengths both require the minimum (padded) payload.
  function automatic logic [15:0] calc_expected(input logic [15:0] tl);
    if (tl >= 16'(TYPE_THRESH))
      return 16'(MIN_PAYLOAD);
    else if (tl < 16'(MIN_PAYLOAD))
      return 16'(MIN_PAYLOAD);
    else
      return tl;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  assign count_inc = sat_inc(byte_count);

`ifdef PAYLOAD_CRC_EN
  logic [31:0] crc_q, crc_n;

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'd0, b};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  assign crc_out = crc_q;
`else
  logic unused_data;
  assign unused_data = ^data;
`endif

  always_comb begin
    state_n    = state;
    expected_n = expected;
    count_n    = byte_count;
    valid_n    = 1'b0;
`ifdef PAYLOAD_CRC_EN
    crc_n      = crc_q;
`endif
    if (tl_load) begin
      // A new header always wins; any byte in the same cycle is dropped.
      state_n    = ARMED;
      expected_n = calc_expected(tl_value);
      count_n    = 16'd0;
`ifdef PAYLOAD_CRC_EN
      crc_n      = 32'hFFFFFFFF;
`endif
    end else begin
      case (state)
        ARMED: begin
          if (enable_payload) begin
            count_n = count_inc;
`ifdef PAYLOAD_CRC_EN
            crc_n   = crc32_byte(crc_q, data);
`endif
            if (count_inc == expected) begin
              state_n = DONE;
              valid_n = 1'b1;
            end
          end else if (byte_count != 16'd0) begin
            // Byte stream stopped before the required size: runt.
            state_n = ERROR;
          end
        end
        DONE: begin
          if (enable_payload) begin
            count_n = count_inc;
`ifdef PAYLOAD_CRC_EN
            crc_n   = crc32_byte(crc_q, data);
`endif
          end
          if (count_n > 16'(MAX_PAYLOAD))
            state_n = ERROR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      expected          <= 16'd0;
      byte_count        <= 16'd0;
      packet_size_valid <= 1'b0;
      packet_size_error <= 1'b0;
`ifdef PAYLOAD_CRC_EN
      crc_q             <= 32'hFFFFFFFF;
`endif
    end else begin
      state             <= state_n;
      expected          <= expected_n;
      byte_count        <= count_n;
      packet_size_valid <= valid_n;
      packet_size_error <= (state_n == ERROR);
`ifdef PAYLOAD_CRC_EN
      crc_q             <= crc_n;
`endif
    end
  end

endmodule
